// File: rtl/bug_ctl.sv
// bug_ctl -- wandering bug sprite controller.
//
// Moves a BUG_W x BUG_H sprite around an H_SIZE x V_SIZE screen once per
// frame. The frame tick is the rising edge of vblnk_in. On each tick in RUN,
// exactly one action happens, in this priority order:
//   respawn (a click is pending)
//   turn    (RUN_FRAMES moves since the last turn or respawn)
//   reverse (the next step would leave the screen)
//   move    (step pixels along the heading)
// A free-running 16-bit LFSR supplies the random positions and headings.
//
// Optional feature: define BUG_SPEEDUP_EN to make every respawn increase the
// step by 1, saturating at 8. When it is undefined, the step stays at STEP.
//
// Ports
//   pclk      in   pixel clock
//   reset     in   synchronous active-high reset
//   vblnk_in  in   vertical blank; its rising edge is the frame tick
//   hit       in   single-cycle pulse: the bug was clicked
//   x_bugpos  out  [11:0] sprite top-left x (registered)
//   y_bugpos  out  [11:0] sprite top-left y (registered)
//   rotation  out  [1:0]  heading 00 up, 01 right, 10 down, 11 left
module bug_ctl #(
  parameter int unsigned H_SIZE     = 1024,
  parameter int unsigned V_SIZE     = 768,
  parameter int unsigned BUG_W      = 53,
  parameter int unsigned BUG_H      = 54,
  parameter int unsigned STEP       = 2,
  parameter int unsigned RUN_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk_in,
  input  logic        hit,
  output logic [11:0] x_bugpos,
  output logic [11:0] y_bugpos,
  output logic [1:0]  rotation
);

  localparam int unsigned X_MAX    = H_SIZE - BUG_W;
  localparam int unsigned Y_MAX    = V_SIZE - BUG_H;
  localparam int unsigned X_CLAMP  = X_MAX - 1;
  localparam int unsigned Y_CLAMP  = Y_MAX - 1;
  localparam int unsigned X_RST    = X_MAX / 2;
  localparam int unsigned Y_RST    = Y_MAX / 2;
  localparam int unsigned CNT_W    = (RUN_FRAMES > 1) ? $clog2(RUN_FRAMES) : 1;
  localparam int unsigned STEP_W   = 4;
  localparam int unsigned STEP_MAX = 8;
  localparam logic [15:0] SEED     = 16'hACE1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic                vblnk_q;
  logic                hit_pend;
  logic [CNT_W-1:0]    frame_cnt;
  logic [STEP_W-1:0]   step;

  logic                tick_c;
  logic                pend_c;
  logic                at_edge_c;
  logic                lfsr_fb_c;
  logic [11:0]         rand_x_c;
  logic [11:0]         rand_y_c;
  logic [12:0]         x13_c;
  logic [12:0]         y13_c;
  logic [12:0]         step13_c;

  // Frame tick, pending click (a click in the tick cycle counts) and LFSR feedback.
  assign tick_c    = vblnk_in & ~vblnk_q;
  assign pend_c    = hit_pend | hit;
  assign lfsr_fb_c = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Respawn coordinates clamped to one pixel inside the legal range.
  assign rand_x_c = (13'(lfsr[9:0]) > 13'(X_CLAMP)) ? 12'(X_CLAMP) : 12'(lfsr[9:0]);
  assign rand_y_c = (13'(lfsr[15:6]) > 13'(Y_CLAMP)) ? 12'(Y_CLAMP) : 12'(lfsr[15:6]);

  // Edge detection in 13 bits so that neither subtraction nor addition wraps.
  assign x13_c    = 13'(x_bugpos);
  assign y13_c    = 13'(y_bugpos);
  assign step13_c = 13'(step);

  always_comb begin
    at_edge_c = 1'b0;
    case (rotation)
      2'b00:   at_edge_c = (y13_c < step13_c);
      2'b01:   at_edge_c = ((x13_c + step13_c) > 13'(X_MAX));
      2'b10:   at_edge_c = ((y13_c + step13_c) > 13'(Y_MAX));
      default: at_edge_c = (x13_c < step13_c);
    endcase
  end

  // Control FSM, LFSR, click latch and sprite state.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      vblnk_q   <= 1'b0;
      hit_pend  <= 1'b0;
      frame_cnt <= '0;
      step      <= STEP_W'(STEP);
      x_bugpos  <= 12'(X_RST);
      y_bugpos  <= 12'(Y_RST);
      rotation  <= 2'b00;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb_c};
      vblnk_q <= vblnk_in;
      if (hit) begin
        hit_pend <= 1'b1;
      end
      if (tick_c) begin
        case (state)
          IDLE: begin
            // First tick only arms the bug; a click stays pending.
            state <= RUN;
          end
          RUN: begin
            if (pend_c) begin
              x_bugpos  <= rand_x_c;
              y_bugpos  <= rand_y_c;
              rotation  <= lfsr[1:0];
              frame_cnt <= '0;
              hit_pend  <= 1'b0;
`ifdef BUG_SPEEDUP_EN
              if (step < STEP_W'(STEP_MAX)) begin
                step <= step + STEP_W'(1);
              end
`endif
            end else if (frame_cnt == CNT_W'(RUN_FRAMES - 1)) begin
              rotation  <= lfsr[1:0];
              frame_cnt <= '0;
            end else if (at_edge_c) begin
              rotation <= rotation ^ 2'b10;
            end else begin
              case (rotation)
                2'b00:   y_bugpos <= y_bugpos - 12'(step);
                2'b01:   x_bugpos <= x_bugpos + 12'(step);
                2'b10:   y_bugpos <= y_bugpos + 12'(step);
                default: x_bugpos <= x_bugpos - 12'(step);
              endcase
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bug_ctl.sv
// Testbench for bug_ctl (default parameters). Directed frame ticks and
// clicks; each tick pushes the expected sprite state into a queue that a
// separate monitor pops one cycle after the tick edge. Between ticks the
// monitor checks that the outputs hold still.
module tb_bug_ctl;

  localparam int X_MAX = 971;   // 1024 - 53
  localparam int Y_MAX = 714;   // 768 - 54
  localparam int X_CLP = 970;
  localparam int Y_CLP = 713;
  localparam int X_RST = 485;
  localparam int Y_RST = 357;
`ifdef BUG_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset;
  logic        vblnk_in;
  logic        hit;
  logic [11:0] x_bugpos;
  logic [11:0] y_bugpos;
  logic [1:0]  rotation;

  always #5 pclk = ~pclk;

  bug_ctl dut (
    .pclk     (pclk),
    .reset    (reset),
    .vblnk_in (vblnk_in),
    .hit      (hit),
    .x_bugpos (x_bugpos),
    .y_bugpos (y_bugpos),
    .rotation (rotation)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct { int x; int y; int r; } exp_t;
  exp_t exp_q[$];

  // Reference LFSR: seed ACE1, taps 16,14,13,11, advances every clock.
  logic [15:0] ref_lfsr;
  always @(posedge pclk) begin
    if (reset) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  // Behavioural expectation of the sprite state.
  int  ex = X_RST, ey = Y_RST, er = 0, ecnt = 0, estep = 2;
  bit  erun = 1'b0, epend = 1'b0;
  logic [15:0] tick_l;

  // act: 0 arm, 1 respawn, 2 turn, 3 reverse, 4 move
  task automatic model_tick(input logic [15:0] l, input bit h, output int act);
    bit pend;
    bit edge_hit;
    int lx, ly;
    pend = epend | h;
    lx = int'(l[9:0]);
    ly = int'(l[15:6]);
    if (!erun) begin
      erun = 1'b1; epend = pend; act = 0;
    end else if (pend) begin
      ex = (lx > X_CLP) ? X_CLP : lx;
      ey = (ly > Y_CLP) ? Y_CLP : ly;
      er = int'(l[1:0]); ecnt = 0; epend = 1'b0; act = 1;
      if (SPEEDUP && estep < 8) estep++;
    end else if (ecnt == 59) begin
      er = int'(l[1:0]); ecnt = 0; act = 2;
    end else begin
      edge_hit = (er == 0 && ey < estep) || (er == 2 && ey + estep > Y_MAX) ||
                 (er == 3 && ex < estep) || (er == 1 && ex + estep > X_MAX);
      if (edge_hit) begin
        er = er ^ 2; act = 3;
      end else begin
        case (er)
          0: ey -= estep;
          1: ex += estep;
          2: ey += estep;
          default: ex -= estep;
        endcase
        ecnt++; act = 4;
      end
    end
  endtask

  // Called at a negedge with vblnk_in low; ends at a negedge with vblnk_in low.
  task automatic do_tick(input bit h, output int act);
    exp_t e;
    tick_l = ref_lfsr;
    model_tick(ref_lfsr, h, act);
    e.x = ex; e.y = ey; e.r = er;
    exp_q.push_back(e);
    vblnk_in = 1'b1; hit = h;
    @(negedge pclk); hit = 1'b0;
    @(negedge pclk); vblnk_in = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic pulse_hit();
    hit = 1'b1; epend = 1'b1;
    @(negedge pclk); hit = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  function automatic bit want(input int kind, input logic [15:0] l);
    if (kind == 0) return (l[1:0] == 2'b00) && l[6] && (int'(l[15:6]) <= 21);
    return (int'(l[9:0]) > X_CLP) && (int'(l[15:6]) > Y_CLP);
  endfunction

  task automatic wait_lfsr(input int kind, output bit found);
    found = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if (want(kind, ref_lfsr)) begin found = 1'b1; break; end
      @(negedge pclk);
    end
    if (!found) check("lfsr_search_timeout", 0, 1);
  endtask

  // Monitor: pops an expectation one cycle after every tick edge.
  initial begin : monitor
    int cx, cy, cr;
    bit r, t, vq;
    exp_t e;
    cx = X_RST; cy = Y_RST; cr = 0; vq = 1'b0;
    forever begin
      @(posedge pclk);
      r  = reset;
      t  = !reset && vblnk_in && !vq;
      vq = reset ? 1'b0 : vblnk_in;
      @(negedge pclk);
      if (r) begin
        cx = X_RST; cy = Y_RST; cr = 0;
        check("reset_x", int'(x_bugpos), X_RST);
        check("reset_y", int'(y_bugpos), Y_RST);
        check("reset_rot", int'(rotation), 0);
      end else if (t) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 0, 1);
        end else begin
          e = exp_q.pop_front();
          cx = e.x; cy = e.y; cr = e.r;
          check("tick_x", int'(x_bugpos), e.x);
          check("tick_y", int'(y_bugpos), e.y);
          check("tick_rot", int'(rotation), e.r);
        end
      end else begin
        check("hold_xyr", int'({x_bugpos, y_bugpos, rotation}), (cx << 14) | (cy << 2) | cr);
      end
    end
  end

  initial begin : stimulus
    int  act;
    bit  found;
    int  px, py, d;
    reset = 1'b1; vblnk_in = 1'b0; hit = 1'b0;
    repeat (3) @(negedge pclk);
    // Click and vblank edge during the last reset cycle must be discarded.
    hit = 1'b1; vblnk_in = 1'b1;
    @(negedge pclk);
    reset = 1'b0; hit = 1'b0; vblnk_in = 1'b0;
    repeat (2) @(negedge pclk);

    do_tick(1'b0, act);
    check("arm_x", int'(x_bugpos), 485);
    check("arm_y", int'(y_bugpos), 357);
    check("arm_rot", int'(rotation), 0);
    do_tick(1'b0, act);
    check("first_move_y", int'(y_bugpos), 355);
    check("first_move_x", int'(x_bugpos), 485);
    check("first_move_rot", int'(rotation), 0);

    repeat (58) do_tick(1'b0, act);
    check("pre_turn_y", int'(y_bugpos), 239);
    do_tick(1'b0, act);
    check("turn_rot", int'(rotation), int'(tick_l[1:0]));
    check("turn_x", int'(x_bugpos), 485);
    check("turn_y", int'(y_bugpos), 239);

    // Click mid-frame, consumed by the next tick.
    pulse_hit();
    do_tick(1'b0, act);
    check("respawn_x_le_970", int'(x_bugpos <= 12'd970), 1);
    check("respawn_y_le_713", int'(y_bugpos <= 12'd713), 1);
    check("respawn_rot", int'(rotation), int'(tick_l[1:0]));

    // Click in the tick cycle with both coordinates over their clamps.
    wait_lfsr(1, found);
    if (found) begin
      do_tick(1'b1, act);
      check("clamp_x", int'(x_bugpos), 970);
      check("clamp_y", int'(y_bugpos), 713);
    end

    // Respawn heading up at a small odd y, then walk into the top edge.
    wait_lfsr(0, found);
    if (found) begin
      do_tick(1'b1, act);
      check("low_spawn_y", int'(y_bugpos), int'(tick_l[15:6]));
      for (int i = 0; i < 20 && ey > 1; i++) do_tick(1'b0, act);
`ifndef BUG_SPEEDUP_EN
      check("top_y", int'(y_bugpos), 1);
      do_tick(1'b0, act);
      check("reverse_rot", int'(rotation), 2);
      check("reverse_y", int'(y_bugpos), 1);
      do_tick(1'b0, act);
      check("after_reverse_y", int'(y_bugpos), 3);
`endif
    end

    // More respawns: step saturates at 8 with speedup, stays 2 without.
    repeat (5) begin
      pulse_hit();
      do_tick(1'b0, act);
    end
    px = ex; py = ey;
    do_tick(1'b0, act);
    if (act == 4) begin
      d = (x_bugpos > 12'(px)) ? int'(x_bugpos) - px : px - int'(x_bugpos);
      d += (y_bugpos > 12'(py)) ? int'(y_bugpos) - py : py - int'(y_bugpos);
      check("step_delta", d, SPEEDUP ? 8 : 2);
    end

    repeat (70) do_tick(1'b0, act);

    repeat (3) @(negedge pclk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
